alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Decode stage that turns 32-bit RV32I instruction words into the control and operand-select bundle consumed by the ALU: `ALU_OP`, `JALR`, immediate, register indices and write/memory enables. It sits between fetch and execute, with a valid/ready handshake on both sides. It adds one register stage plus a one-entry skid buffer, so backpressure from execute never drops or duplicates an instruction. Any instruction the ALU cannot execute (including the unimplemented `ALU_OP` 110 class) is flagged illegal rather than silently mis-decoded.

## Interface
- No parameters; widths fixed at XLEN = 32.
- `CLK` in 1 — single clock, rising edge.
- `RST_N` in 1 — asynchronous, active-low reset.
- `FLUSH` in 1 — synchronous; discards all held instructions.
- `IN_VALID` in 1 — fetch presents an instruction.
- `IN_READY` out 1 — stage can accept the instruction.
- `INSTR` in 32 — instruction word.
- `PC_IN` in 32 — address of `INSTR`.
- `OUT_VALID` out 1 — decoded bundle valid.
- `OUT_READY` in 1 — execute accepts the bundle.
- `ALU_OP` out 3 — ALU operation code:
  - 000 ADD, 001 SLL, 010 SUB, 011 SRL
  - 100 XOR, 101 SRA, 111 AND
  - 110 is never emitted.
- `JALR` out 1 — ALU result LSB is cleared (JALR target).
- `OP2_SEL` out 1 — 1 selects `IMM` as OP2; 0 selects rs2.
- `RS1` out 5, `RS2` out 5, `RD` out 5 — register indices.
- `IMM` out 32 — sign-extended immediate (I or S format).
- `REG_WE` out 1, `MEM_RD` out 1, `MEM_WR` out 1 — enables.
- `ILLEGAL` out 1 — instruction is unsupported.
- `PC_OUT` out 32 — `PC_IN` carried with the bundle.

## Operation
- **OP-IMM (0010011):**
  - funct3 000 → ADD.
  - 100 → XOR.
  - 111 → AND.
  - 001 → SLL; requires funct7 = 0000000.
  - 101 → SRL when funct7 = 0000000, SRA when funct7 = 0100000.
  - Settings: `OP2_SEL`=1, `IMM` = sign-extended I-immediate. For shifts, `IMM` = zero-extended shamt (`INSTR[24:20]`).
- **OP (0110011):**
  - Same mapping as OP-IMM, plus funct3 000 with funct7 0100000 → SUB.
  - funct7 must be 0000000 or 0100000 as appropriate.
  - Settings: `OP2_SEL`=0, `IMM`=0.
- **JALR (1100111):** funct3 must be 000 → ADD, `JALR`=1, `OP2_SEL`=1, I-immediate.
- **LW (0000011, funct3 010):** ADD, I-immediate, `MEM_RD`=1.
- **SW (0100011, funct3 010):** ADD, S-immediate, `MEM_WR`=1, `REG_WE`=0.
- **REG_WE:** 1 for OP-IMM, OP, JALR and LW when `RD` ≠ 0; forced 0 when `RD` = 0.
- **Illegal instructions:** anything else, including funct3 010, 011 and 110 in OP/OP-IMM, and `INSTR[1:0]` ≠ 11.
  - Outputs: `ILLEGAL`=1, `ALU_OP`=000, `JALR`=0, `REG_WE`=0, `MEM_RD`=0, `MEM_WR`=0.
  - The bundle still passes through the handshake normally.
- **Transfers:**
  - Input transfer occurs when `IN_VALID` & `IN_READY`.
  - Output transfer occurs when `OUT_VALID` & `OUT_READY`.
- **Storage and states:** an output register plus a skid register.
  - States: EMPTY, ONE (output register valid), TWO (both registers valid).
  - EMPTY → ONE on an input transfer.
  - ONE → TWO on an input transfer without an output transfer.
  - ONE → EMPTY on an output transfer without an input transfer.
  - ONE stays ONE on simultaneous input and output transfers.
  - TWO → ONE on an output transfer; the skid entry moves to the output register.
- **`IN_READY`** = (state ≠ TWO); it is registered and not combinationally dependent on `OUT_READY`.
- **`FLUSH`** has priority over everything:
  - Next state is EMPTY.
  - Any `IN_VALID` in the same cycle is dropped.
  - `OUT_VALID`=0 on the following cycle.

## Timing
- **Reset** (asynchronous assert, synchronous deassert handled upstream): state EMPTY, `OUT_VALID`=0, `IN_READY`=1. All bundle outputs are 0, including `ILLEGAL`, `PC_OUT` and `IMM`.
- **Latency:** an instruction accepted at edge N appears with `OUT_VALID`=1 after edge N, i.e. one cycle.
- **Throughput:** one instruction per cycle while `OUT_READY`=1.
- **Bundle stability:** all outputs stay stable while `OUT_VALID`=1 and `OUT_READY`=0.
- **Skid absorption:** after `OUT_READY` falls, the stage absorbs at most one more instruction. `IN_READY` falls on the edge the skid register fills.
- **Reset mid-operation:** both entries are lost; the stage returns to the reset values immediately.

## Structure
- Shared header `riscv_defs.vh` holds:
  - opcode constants, funct3/funct7 constants;
  - `ALU_OP` encodings (shared with the ALU);
  - the bundle width.
- Sub-module `decode_skid`: generic two-entry valid/ready pipe register with flush, parameterised by payload width.
- The decode logic itself is combinational on `INSTR` and feeds `decode_skid`.

## Test plan
- **Reset:** assert `RST_N`=0 mid-stream → `OUT_VALID`=0, `IN_READY`=1, and all outputs 0 immediately.
- **ADDI 0x00500093:**
  - Expect `ALU_OP`=000, `IMM`=5, `OP2_SEL`=1, `RD`=1, `REG_WE`=1 one cycle after accept.
- **SRAI 0x4050D113:**
  - Expect `ALU_OP`=101, `IMM`=5, `RS1`=1, `RD`=2.
- **SUB 0x402081B3:**
  - Expect `ALU_OP`=010, `OP2_SEL`=0, `RS2`=2.
- **JALR 0x000280E7:**
  - Expect `JALR`=1, `ALU_OP`=000, `RS1`=5, `IMM`=0.
- **Illegal words:**
  - ORI 0x00106093 → `ILLEGAL`=1, `REG_WE`=0, `ALU_OP`=000.
  - 0xFFFFFFFF → `ILLEGAL`=1.
- **Backpressure:**
  - Hold `OUT_READY`=0 and stream 3 instructions → `IN_READY` drops after the 2nd accept; the 3rd is held by fetch.
  - Release `OUT_READY` → all 3 are delivered in order, no loss, no duplicates.
- **Flush:**
  - Assert `FLUSH` while in TWO with `IN_VALID`=1 → next cycle `OUT_VALID`=0, `IN_READY`=1, nothing is emitted afterward.

Source files
------------

// File: rtl/alu_decode_stage_pkg.sv
// Shared RV32I decode constants, ALU op encodings and the
// decode-to-execute bundle layout.
package alu_decode_stage_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SLL = 3'b001,
        ALU_SUB = 3'b010,
        ALU_SRL = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SRA = 3'b101,
        ALU_AND = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } skid_state_e;

    typedef struct packed {
        logic        illegal;
        alu_op_e     alu_op;
        logic        jalr;
        logic        op2_sel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] pc;
    } bundle_t;

    localparam int BUNDLE_W = $bits(bundle_t);

endpackage

// File: rtl/decode_skid.sv
// Two-entry valid/ready pipe register: output register plus skid
// register, with a registered ready and synchronous flush.
module decode_skid
    import alu_decode_stage_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_fire;
    logic         out_fire;

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    out_d   = in_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    out_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = ST_TWO;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // ready is low here, so only the drain case exists
                if (out_fire) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I ALU decode stage: combinational decode of INSTR into the
// execute bundle, registered through a two-entry skid pipe.
module alu_decode_stage
    import alu_decode_stage_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        FLUSH,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] INSTR,
    input  logic [31:0] PC_IN,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [2:0]  ALU_OP,
    output logic        JALR,
    output logic        OP2_SEL,
    output logic [4:0]  RS1,
    output logic [4:0]  RS2,
    output logic [4:0]  RD,
    output logic [31:0] IMM,
    output logic        REG_WE,
    output logic        MEM_RD,
    output logic        MEM_WR,
    output logic        ILLEGAL,
    output logic [31:0] PC_OUT
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] shamt;

    assign opc   = INSTR[6:0];
    assign f3    = INSTR[14:12];
    assign f7    = INSTR[31:25];
    assign i_imm = {{20{INSTR[31]}}, INSTR[31:20]};
    assign s_imm = {{20{INSTR[31]}}, INSTR[31:25], INSTR[11:7]};
    assign shamt = {27'b0, INSTR[24:20]};

    bundle_t     dec;
    bundle_t     q;
    logic        legal;
    logic        wr;
    alu_op_e     alu;
    logic        jalr;
    logic        op2;
    logic [31:0] imm;
    logic        mrd;
    logic        mwr;

    always_comb begin
        legal = 1'b0;
        wr    = 1'b0;
        alu   = ALU_ADD;
        jalr  = 1'b0;
        op2   = 1'b0;
        imm   = '0;
        mrd   = 1'b0;
        mwr   = 1'b0;
        case (opc)
            OPC_OP_IMM: begin
                op2 = 1'b1;
                imm = i_imm;
                wr  = 1'b1;
                case (f3)
                    F3_ADD: begin alu = ALU_ADD; legal = 1'b1; end
                    F3_XOR: begin alu = ALU_XOR; legal = 1'b1; end
                    F3_AND: begin alu = ALU_AND; legal = 1'b1; end
                    F3_SLL: begin
                        alu   = ALU_SLL;
                        imm   = shamt;
                        legal = (f7 == F7_BASE);
                    end
                    F3_SR: begin
                        imm = shamt;
                        if (f7 == F7_BASE) begin
                            alu = ALU_SRL; legal = 1'b1;
                        end else if (f7 == F7_ALT) begin
                            alu = ALU_SRA; legal = 1'b1;
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP: begin
                wr = 1'b1;
                case (f3)
                    F3_ADD: begin
                        if (f7 == F7_BASE) begin
                            alu = ALU_ADD; legal = 1'b1;
                        end else if (f7 == F7_ALT) begin
                            alu = ALU_SUB; legal = 1'b1;
                        end
                    end
                    F3_XOR: begin alu = ALU_XOR; legal = (f7 == F7_BASE); end
                    F3_AND: begin alu = ALU_AND; legal = (f7 == F7_BASE); end
                    F3_SLL: begin alu = ALU_SLL; legal = (f7 == F7_BASE); end
                    F3_SR: begin
                        if (f7 == F7_BASE) begin
                            alu = ALU_SRL; legal = 1'b1;
                        end else if (f7 == F7_ALT) begin
                            alu = ALU_SRA; legal = 1'b1;
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_JALR: begin
                legal = (f3 == F3_ADD);
                jalr  = 1'b1;
                op2   = 1'b1;
                imm   = i_imm;
                wr    = 1'b1;
            end
            OPC_LOAD: begin
                legal = (f3 == F3_W);
                op2   = 1'b1;
                imm   = i_imm;
                mrd   = 1'b1;
                wr    = 1'b1;
            end
            OPC_STORE: begin
                legal = (f3 == F3_W);
                op2   = 1'b1;
                imm   = s_imm;
                mwr   = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        // an illegal word becomes an inert bundle that only carries its PC
        dec         = '0;
        dec.pc      = PC_IN;
        dec.illegal = ~legal;
        if (legal) begin
            dec.alu_op  = alu;
            dec.jalr    = jalr;
            dec.op2_sel = op2;
            dec.rs1     = INSTR[19:15];
            dec.rs2     = INSTR[24:20];
            dec.rd      = INSTR[11:7];
            dec.imm     = imm;
            dec.reg_we  = wr & (INSTR[11:7] != 5'd0);
            dec.mem_rd  = mrd;
            dec.mem_wr  = mwr;
        end
    end

    decode_skid #(
        .W(BUNDLE_W)
    ) u_skid (
        .clk      (CLK),
        .rst_n    (RST_N),
        .flush    (FLUSH),
        .in_valid (IN_VALID),
        .in_ready (IN_READY),
        .in_data  (dec),
        .out_valid(OUT_VALID),
        .out_ready(OUT_READY),
        .out_data (q)
    );

    assign ALU_OP  = q.alu_op;
    assign JALR    = q.jalr;
    assign OP2_SEL = q.op2_sel;
    assign RS1     = q.rs1;
    assign RS2     = q.rs2;
    assign RD      = q.rd;
    assign IMM     = q.imm;
    assign REG_WE  = q.reg_we;
    assign MEM_RD  = q.mem_rd;
    assign MEM_WR  = q.mem_wr;
    assign ILLEGAL = q.illegal;
    assign PC_OUT  = q.pc;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode vector table plus
// backpressure, flush and mid-stream reset sequences.
module tb_alu_decode_stage;
    import alu_decode_stage_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N, FLUSH, IN_VALID, OUT_READY;
    logic [31:0] INSTR, PC_IN;
    logic        IN_READY, OUT_VALID;
    logic [2:0]  ALU_OP;
    logic        JALR, OP2_SEL, REG_WE, MEM_RD, MEM_WR, ILLEGAL;
    logic [4:0]  RS1, RS2, RD;
    logic [31:0] IMM, PC_OUT;

    alu_decode_stage dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .INSTR(INSTR), .PC_IN(PC_IN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .ALU_OP(ALU_OP), .JALR(JALR), .OP2_SEL(OP2_SEL),
        .RS1(RS1), .RS2(RS2), .RD(RD), .IMM(IMM),
        .REG_WE(REG_WE), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
        .ILLEGAL(ILLEGAL), .PC_OUT(PC_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        bundle_t     exp;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    int total = 0;
    int bad = 0;
    logic [31:0] got_q[$];

    // inputs only change just after posedge, so a handshake seen here
    // is exactly the transfer taken on the next rising edge
    always @(negedge CLK)
        if (RST_N && OUT_VALID && OUT_READY && !FLUSH)
            got_q.push_back(PC_OUT);

    task automatic chk(input string nm, input logic [127:0] a,
                       input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic bundle_t mk(
        input logic [2:0] op, input logic j, input logic o2,
        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
        input logic [31:0] imm, input logic we, input logic mr,
        input logic mw, input logic il);
        bundle_t b;
        b.alu_op  = alu_op_e'(op);
        b.jalr    = j;
        b.op2_sel = o2;
        b.rs1     = r1;
        b.rs2     = r2;
        b.rd      = rd;
        b.imm     = imm;
        b.reg_we  = we;
        b.mem_rd  = mr;
        b.mem_wr  = mw;
        b.illegal = il;
        b.pc      = 32'd0;
        return b;
    endfunction

    function automatic bundle_t ill();
        return mk(3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0,
                  1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    function automatic bundle_t cur();
        bundle_t b;
        b.alu_op  = alu_op_e'(ALU_OP);
        b.jalr    = JALR;
        b.op2_sel = OP2_SEL;
        b.rs1     = RS1;
        b.rs2     = RS2;
        b.rd      = RD;
        b.imm     = IMM;
        b.reg_we  = REG_WE;
        b.mem_rd  = MEM_RD;
        b.mem_wr  = MEM_WR;
        b.illegal = ILLEGAL;
        b.pc      = PC_OUT;
        return b;
    endfunction

    bundle_t e;

    initial begin
        vecs[0]  = '{32'h00500093, mk(3'd0,1'b0,1'b1,5'd0,5'd5,5'd1,32'd5,1'b1,1'b0,1'b0,1'b0)};
        vecs[1]  = '{32'h4050D113, mk(3'd5,1'b0,1'b1,5'd1,5'd5,5'd2,32'd5,1'b1,1'b0,1'b0,1'b0)};
        vecs[2]  = '{32'h402081B3, mk(3'd2,1'b0,1'b0,5'd1,5'd2,5'd3,32'd0,1'b1,1'b0,1'b0,1'b0)};
        vecs[3]  = '{32'h000280E7, mk(3'd0,1'b1,1'b1,5'd5,5'd0,5'd1,32'd0,1'b1,1'b0,1'b0,1'b0)};
        vecs[4]  = '{32'h00106093, ill()};
        vecs[5]  = '{32'hFFFFFFFF, ill()};
        vecs[6]  = '{32'h0080A183, mk(3'd0,1'b0,1'b1,5'd1,5'd8,5'd3,32'd8,1'b1,1'b1,1'b0,1'b0)};
        vecs[7]  = '{32'hFE112E23, mk(3'd0,1'b0,1'b1,5'd2,5'd1,5'd28,32'hFFFFFFFC,1'b0,1'b0,1'b1,1'b0)};
        vecs[8]  = '{32'hFFF00013, mk(3'd0,1'b0,1'b1,5'd0,5'd31,5'd0,32'hFFFFFFFF,1'b0,1'b0,1'b0,1'b0)};
        vecs[9]  = '{32'h02009093, ill()};
        vecs[10] = '{32'h007352B3, mk(3'd3,1'b0,1'b0,5'd6,5'd7,5'd5,32'd0,1'b1,1'b0,1'b0,1'b0)};
        vecs[11] = '{32'h4073C2B3, ill()};
        vecs[12] = '{32'h7FF17093, mk(3'd7,1'b0,1'b1,5'd2,5'd31,5'd1,32'h7FF,1'b1,1'b0,1'b0,1'b0)};
        vecs[13] = '{32'h000290E7, ill()};
        vecs[14] = '{32'h00500090, ill()};
        vecs[15] = '{32'h01F21193, mk(3'd1,1'b0,1'b1,5'd4,5'd31,5'd3,32'd31,1'b1,1'b0,1'b0,1'b0)};
        vecs[16] = '{32'h403150B3, mk(3'd5,1'b0,1'b0,5'd2,5'd3,5'd1,32'd0,1'b1,1'b0,1'b0,1'b0)};
        vecs[17] = '{32'h00008183, ill()};

        RST_N = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        INSTR = 32'd0; PC_IN = 32'd0;
        step();
        step();
        chk("rst_out_valid", 128'(OUT_VALID), 128'(1'b0));
        chk("rst_in_ready", 128'(IN_READY), 128'(1'b1));
        chk("rst_bundle", 128'(cur()), 128'(0));
        RST_N = 1'b1;
        step();

        // back-to-back stream through the decoder at full rate
        got_q.delete();
        OUT_READY = 1'b1;
        for (int i = 0; i < NV; i++) begin
            IN_VALID = 1'b1;
            INSTR = vecs[i].instr;
            PC_IN = 32'h1000 + 32'(i) * 32'd4;
            step();
            e = vecs[i].exp;
            e.pc = PC_IN;
            chk($sformatf("vec%0d_valid", i), 128'(OUT_VALID), 128'(1'b1));
            chk($sformatf("vec%0d_in_ready", i), 128'(IN_READY), 128'(1'b1));
            chk($sformatf("vec%0d_bundle", i), 128'(cur()), 128'(e));
        end
        IN_VALID = 1'b0;
        step();
        chk("stream_drained", 128'(OUT_VALID), 128'(1'b0));
        chk("stream_count", 128'(got_q.size()), 128'(NV));
        for (int i = 0; i < NV && i < got_q.size(); i++)
            chk($sformatf("stream_order%0d", i), 128'(got_q[i]),
                128'(32'h1000 + 32'(i) * 32'd4));

        // backpressure: two absorbed, third held by fetch
        got_q.delete();
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; INSTR = vecs[0].instr; PC_IN = 32'h2000;
        step();
        chk("bp_ready_after1", 128'(IN_READY), 128'(1'b1));
        chk("bp_valid_after1", 128'(OUT_VALID), 128'(1'b1));
        INSTR = vecs[2].instr; PC_IN = 32'h2004;
        step();
        chk("bp_ready_after2", 128'(IN_READY), 128'(1'b0));
        INSTR = vecs[1].instr; PC_IN = 32'h2008;
        e = vecs[0].exp;
        e.pc = 32'h2000;
        step();
        chk("bp_hold_ready", 128'(IN_READY), 128'(1'b0));
        chk("bp_stable1", 128'(cur()), 128'(e));
        step();
        chk("bp_stable2", 128'(cur()), 128'(e));
        OUT_READY = 1'b1;
        step();
        chk("bp_second_pc", 128'(PC_OUT), 128'(32'h2004));
        chk("bp_ready_back", 128'(IN_READY), 128'(1'b1));
        step();
        e = vecs[1].exp;
        e.pc = 32'h2008;
        chk("bp_third_bundle", 128'(cur()), 128'(e));
        IN_VALID = 1'b0;
        step();
        chk("bp_drained", 128'(OUT_VALID), 128'(1'b0));
        chk("bp_count", 128'(got_q.size()), 128'(3));
        for (int i = 0; i < 3 && i < got_q.size(); i++)
            chk($sformatf("bp_order%0d", i), 128'(got_q[i]),
                128'(32'h2000 + 32'(i) * 32'd4));

        // flush while both entries are full
        got_q.delete();
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; INSTR = vecs[0].instr; PC_IN = 32'h3000;
        step();
        PC_IN = 32'h3004;
        step();
        chk("fl_two_ready", 128'(IN_READY), 128'(1'b0));
        PC_IN = 32'h3008; FLUSH = 1'b1;
        step();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        chk("fl_valid", 128'(OUT_VALID), 128'(1'b0));
        chk("fl_ready", 128'(IN_READY), 128'(1'b1));
        OUT_READY = 1'b1;
        repeat (3) step();
        chk("fl_quiet", 128'(OUT_VALID), 128'(1'b0));
        chk("fl_none_out", 128'(got_q.size()), 128'(0));

        // flush from one entry drops the concurrent input too
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; PC_IN = 32'h3100;
        step();
        PC_IN = 32'h3104; FLUSH = 1'b1;
        step();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        chk("fl1_valid", 128'(OUT_VALID), 128'(1'b0));
        OUT_READY = 1'b1;
        repeat (2) step();
        chk("fl1_none_out", 128'(got_q.size()), 128'(0));
        IN_VALID = 1'b1; PC_IN = 32'h3200;
        step();
        IN_VALID = 1'b0;
        chk("fl_recover_valid", 128'(OUT_VALID), 128'(1'b1));
        chk("fl_recover_pc", 128'(PC_OUT), 128'(32'h3200));
        step();

        // asynchronous reset with both entries full
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; INSTR = vecs[7].instr; PC_IN = 32'h4000;
        step();
        PC_IN = 32'h4004;
        step();
        IN_VALID = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        chk("mrst_valid", 128'(OUT_VALID), 128'(1'b0));
        chk("mrst_ready", 128'(IN_READY), 128'(1'b1));
        chk("mrst_bundle", 128'(cur()), 128'(0));
        step();
        RST_N = 1'b1;
        OUT_READY = 1'b1;
        step();
        chk("mrst_nothing", 128'(OUT_VALID), 128'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
